pipeline_hazard_ctrl: RTL
=========================

# pipeline_hazard_ctrl

Hazard and scheduling controller for the five-stage MIPS pipeline. It drives the EX-stage operand-forwarding selects, inserts load-use and structural stalls, and flushes on taken branches. It also sequences the shared multi-cycle multiply/divide unit through a busy counter, and keeps a saturating stall-cycle performance counter. It sits beside the ID/EX pipeline registers and controls the PC, IF/ID and ID/EX enables.

## Interface
- MD_LATENCY, 32, cycles the mul/div unit stays occupied after issue (must be ≥2)
- STALL_CNT_W, 16, width of the stall performance counter
- clk  in  1  pipeline clock, rising edge
- reset  in  1  asynchronous, active-low reset
- ID_rs, ID_rt  in  5 each  source registers of the instruction in ID
- ID_uses_rs, ID_uses_rt  in  1 each  ID instruction actually reads that source
- ID_md_op  in  1  ID instruction is mult/multu/div/divu
- ID_md_read  in  1  ID instruction is mfhi/mflo
- EX_rs, EX_rt  in  5 each  source registers of the instruction in EX
- EX_MemRead  in  1  EX instruction is a load
- EX_rd  in  5  destination of the EX instruction
- MEM_RegWrite, MEM_rd  in  1, 5  EX/MEM writeback info
- WB_RegWrite, WB_rd  in  1, 5  MEM/WB writeback info
- EX_branch_taken  in  1  branch/jump resolved taken in EX
- ForwardA, ForwardB  out  2 each  00 register file, 01 MEM/WB data, 10 EX/MEM data
- PC_stall, IFID_stall  out  1  hold the PC and the IF/ID register
- IDEX_bubble  out  1  load a NOP into ID/EX
- IFID_flush  out  1  load a NOP into IF/ID
- md_start  out  1  issue pulse to the mul/div unit
- md_busy  out  1  mul/div unit occupied
- stall_cycles  out  STALL_CNT_W  saturating count of stalled cycles

## Operation
- Forwarding is combinational. ForwardA = 10 if MEM_RegWrite, MEM_rd≠0 and MEM_rd==EX_rs. Otherwise 01 if WB_RegWrite, WB_rd≠0 and WB_rd==EX_rs. Otherwise 00. ForwardB uses the same rule with EX_rt. EX/MEM has priority over MEM/WB.
- Register 0 is never forwarded.
- load_use = EX_MemRead, EX_rd≠0, and EX_rd matches a used ID source (ID_rs with ID_uses_rs, or ID_rt with ID_uses_rt).
- md_hazard = md_busy and (ID_md_op or ID_md_read).
- stall = (load_use or md_hazard) and not EX_branch_taken.
- On stall: PC_stall=IFID_stall=IDEX_bubble=1.
- On EX_branch_taken: IFID_flush=IDEX_bubble=1 and PC_stall=IFID_stall=0. A flush overrides any stall in the same cycle.
- md_start = ID_md_op, not stall, and not EX_branch_taken. This is the cycle the mul/div instruction moves ID→EX.
- Mul/div FSM has two states:
  - IDLE: md_busy=0. On md_start, go to BUSY and load count=MD_LATENCY−1.
  - BUSY: md_busy=1. Decrement count each cycle. When count==1 the next state is IDLE.
  - md_start is never asserted while in BUSY, because md_hazard stalls the ID instruction.
- Counter width is $clog2(MD_LATENCY).
- stall_cycles increments on each cycle with stall=1 and saturates at all-ones.
- A branch flush never cancels an in-flight mul/div, because the issued instruction is already past ID.

## Timing
- Reset values: FSM IDLE, count 0, stall_cycles 0, md_busy 0.
- With reset asserted, all combinational outputs are 0 given idle inputs.
- Forwarding, stall, flush and md_start have zero latency and are pure functions of the current inputs and state.
- md_busy rises on the edge after md_start and stays high for exactly MD_LATENCY−1 cycles.
- The earliest a dependent mfhi or a second mul/div can issue is MD_LATENCY cycles after md_start.
- A load-use stall lasts exactly one cycle. On the next cycle the load is in MEM and the result is forwarded from MEM/WB.
- Reset mid-BUSY returns the FSM to IDLE immediately (asynchronous). No md_start is generated during reset.

## Structure
- Shared package `pipeline_pkg`:
  - forward-select constants FWD_REG=2'b00, FWD_MEMWB=2'b01, FWD_EXMEM=2'b10 (shared with the EX stage)
  - mul/div FSM state enum
- One sub-module, `forward_unit`: the combinational ForwardA/ForwardB logic, instantiated once.
- Stall/flush logic, the mul/div FSM and the performance counter live in the top module.

## Test plan
- Forwarding priority: MEM_rd=WB_rd=EX_rs=5, both RegWrite=1 → ForwardA=10. Set MEM_RegWrite=0 → ForwardA=01. Set EX_rs=0 with rd=0 → ForwardA=00.
- Load-use: EX_MemRead=1, EX_rd=8, ID_rt=8, ID_uses_rt=1 → one cycle of PC_stall=IFID_stall=IDEX_bubble=1 and stall_cycles 0→1. With ID_uses_rt=0 → no stall.
- Branch vs stall: load_use true and EX_branch_taken=1 in the same cycle → IFID_flush=1, IDEX_bubble=1, PC_stall=0, stall_cycles unchanged.
- Mul/div sequencing (MD_LATENCY=4):
  - ID_md_op=1 → md_start pulse, then md_busy high for 3 cycles.
  - mfhi held in ID stalls those 3 cycles and issues on the 4th.
  - stall_cycles=3.
- Reset during BUSY: assert reset 1 cycle after md_start → md_busy=0 asynchronously and count=0. After release, ID_md_op=1 issues immediately.
- Saturation (STALL_CNT_W=4): hold load_use for 20 cycles → stall_cycles stops at 15.

Source files
------------

// File: rtl/pipeline_pkg.sv
`default_nettype none
// ============================================================================
// Module   : pipeline_pkg
// Brief    : Shared forward-select encodings and mul/div sequencer states.
// Revision : 1.0
// ============================================================================
package pipeline_pkg;

    // Forward-select encodings, also decoded by the EX-stage operand muxes
    localparam logic [1:0] FWD_REG   = 2'b00;
    localparam logic [1:0] FWD_MEMWB = 2'b01;
    localparam logic [1:0] FWD_EXMEM = 2'b10;

    typedef enum logic [0:0] {
        MD_IDLE = 1'b0,
        MD_BUSY = 1'b1
    } md_state_t;

endpackage : pipeline_pkg
`default_nettype wire

// File: rtl/forward_unit.sv
`default_nettype none
// ============================================================================
// Module   : forward_unit
// Brief    : EX-stage operand forwarding selects; EX/MEM beats MEM/WB.
// Revision : 1.0
// ============================================================================
module forward_unit
    import pipeline_pkg::*;
(
    input  logic       MEM_RegWrite,
    input  logic [4:0] MEM_rd,
    input  logic       WB_RegWrite,
    input  logic [4:0] WB_rd,
    input  logic [4:0] EX_rs,
    input  logic [4:0] EX_rt,
    output logic [1:0] ForwardA,
    output logic [1:0] ForwardB
);

    // $zero is hard-wired, so a write to r0 must never be forwarded
    function automatic logic [1:0] fwd_select(
        input logic       mem_we,
        input logic [4:0] mem_dst,
        input logic       wb_we,
        input logic [4:0] wb_dst,
        input logic [4:0] src
    );
        if (mem_we && (mem_dst != 5'd0) && (mem_dst == src)) begin
            return FWD_EXMEM;
        end else if (wb_we && (wb_dst != 5'd0) && (wb_dst == src)) begin
            return FWD_MEMWB;
        end else begin
            return FWD_REG;
        end
    endfunction

    assign ForwardA = fwd_select(MEM_RegWrite, MEM_rd, WB_RegWrite, WB_rd, EX_rs);
    assign ForwardB = fwd_select(MEM_RegWrite, MEM_rd, WB_RegWrite, WB_rd, EX_rt);

endmodule : forward_unit
`default_nettype wire

// File: rtl/pipeline_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : pipeline_hazard_ctrl
// Brief    : Forwarding, stall/flush, mul/div sequencing and stall counter.
// Revision : 1.0
// ============================================================================
module pipeline_hazard_ctrl
    import pipeline_pkg::*;
#(
    parameter int MD_LATENCY  = 32,
    parameter int STALL_CNT_W = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [4:0]             ID_rs,
    input  logic [4:0]             ID_rt,
    input  logic                   ID_uses_rs,
    input  logic                   ID_uses_rt,
    input  logic                   ID_md_op,
    input  logic                   ID_md_read,
    input  logic [4:0]             EX_rs,
    input  logic [4:0]             EX_rt,
    input  logic                   EX_MemRead,
    input  logic [4:0]             EX_rd,
    input  logic                   MEM_RegWrite,
    input  logic [4:0]             MEM_rd,
    input  logic                   WB_RegWrite,
    input  logic [4:0]             WB_rd,
    input  logic                   EX_branch_taken,
    output logic [1:0]             ForwardA,
    output logic [1:0]             ForwardB,
    output logic                   PC_stall,
    output logic                   IFID_stall,
    output logic                   IDEX_bubble,
    output logic                   IFID_flush,
    output logic                   md_start,
    output logic                   md_busy,
    output logic [STALL_CNT_W-1:0] stall_cycles
);

    localparam int                c_cnt_w   = $clog2(MD_LATENCY);
    localparam logic [c_cnt_w-1:0] c_md_load = c_cnt_w'(MD_LATENCY - 1);
    localparam logic [c_cnt_w-1:0] c_md_last = c_cnt_w'(1);

    generate
        if (MD_LATENCY < 2) begin : g_param_check
            $error("pipeline_hazard_ctrl: MD_LATENCY must be at least 2");
        end
    endgenerate

    md_state_t          r_md_state;
    md_state_t          w_md_state_nxt;
    logic [c_cnt_w-1:0] r_md_count;
    logic [c_cnt_w-1:0] w_md_count_nxt;
    logic               w_load_use;
    logic               w_md_hazard;
    logic               w_stall;

    forward_unit u_forward_unit (
        .MEM_RegWrite (MEM_RegWrite),
        .MEM_rd       (MEM_rd),
        .WB_RegWrite  (WB_RegWrite),
        .WB_rd        (WB_rd),
        .EX_rs        (EX_rs),
        .EX_rt        (EX_rt),
        .ForwardA     (ForwardA),
        .ForwardB     (ForwardB)
    );

    assign w_load_use  = EX_MemRead && (EX_rd != 5'd0) &&
                         ((ID_uses_rs && (ID_rs == EX_rd)) ||
                          (ID_uses_rt && (ID_rt == EX_rd)));
    assign w_md_hazard = md_busy && (ID_md_op || ID_md_read);
    // A taken branch squashes the ID instruction, so its hazard is moot
    assign w_stall     = (w_load_use || w_md_hazard) && !EX_branch_taken;

    assign PC_stall    = w_stall;
    assign IFID_stall  = w_stall;
    assign IDEX_bubble = w_stall || EX_branch_taken;
    assign IFID_flush  = EX_branch_taken;
    assign md_start    = reset && ID_md_op && !w_stall && !EX_branch_taken;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_md_state <= MD_IDLE;
            r_md_count <= '0;
        end else begin
            r_md_state <= w_md_state_nxt;
            r_md_count <= w_md_count_nxt;
        end
    end

    always_comb begin
        w_md_state_nxt = r_md_state;
        w_md_count_nxt = r_md_count;
        md_busy        = 1'b0;
        case (r_md_state)
            MD_IDLE: begin
                if (md_start) begin
                    w_md_state_nxt = MD_BUSY;
                    w_md_count_nxt = c_md_load;
                end
            end
            MD_BUSY: begin
                md_busy        = 1'b1;
                w_md_count_nxt = r_md_count - c_md_last;
                if (r_md_count == c_md_last) begin
                    w_md_state_nxt = MD_IDLE;
                end
            end
            default: begin
                w_md_state_nxt = MD_IDLE;
                w_md_count_nxt = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stall_cycles <= '0;
        end else if (w_stall && (stall_cycles != '1)) begin
            stall_cycles <= stall_cycles + 1'b1;
        end
    end

endmodule : pipeline_hazard_ctrl
`default_nettype wire
